// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - divided-clock edge strobes, period/high-time measurement and lock monitor
//
// Ports:
//   clk        in   system clock; clk_in is synchronous to it
//   reset      in   synchronous, active-high reset
//   clk_in     in   divided clock, sampled directly
//   err_clr    in   one-cycle pulse clearing the sticky err flag
//   rise_stb   out  one-cycle pulse per clk_in rising edge
//   fall_stb   out  one-cycle pulse per clk_in falling edge
//   period     out  last measured period in clk cycles
//   period_vld out  one-cycle pulse when period updates
//   high_time  out  last measured high time in clk cycles
//   locked     out  LOCK_CNT consecutive in-tolerance periods seen
//   err        out  sticky loss-of-lock flag
module clk_div_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             err_clr,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             err
);

  localparam int GW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   EXP_X   = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);
  localparam logic [GW-1:0]    LOCK_X  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, FIRST, TRACK} state_t;

  state_t           state_q;
  logic             in_q, in_qq;
  logic             armed_q;
  logic [CNT_W-1:0] per_cnt_q, hi_cnt_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             period_vld_q, locked_q, err_q;
  logic [GW-1:0]    good_cnt_q;

  logic [CNT_W-1:0] per_cnt_inc_d, hi_cnt_inc_d;
  logic [CNT_W:0]   per_x, diff;
  logic             good, per_max, timeout, upd, err_set;
  logic [GW-1:0]    good_cnt_d;
  logic             err_d;

  // armed_q keeps a level that is already high at reset release from being
  // mistaken for a rise; it sets once clk_in has been sampled low.
  assign rise_stb = in_q & ~in_qq & armed_q;
  assign fall_stb = ~in_q & in_qq;

  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign high_time  = high_time_q;
  assign locked     = locked_q;
  assign err        = err_q;

  always_comb begin
    per_cnt_inc_d = per_cnt_q + CNT_ONE;
    hi_cnt_inc_d  = hi_cnt_q + CNT_ONE;
    // Widened by one bit so the absolute difference never wraps.
    per_x   = {1'b0, per_cnt_q};
    diff    = (per_x >= EXP_X) ? (per_x - EXP_X) : (EXP_X - per_x);
    good    = (diff <= TOL_X);
    per_max = (per_cnt_q == CNT_MAX);
    timeout = (state_q != IDLE) && per_max;
    upd     = (state_q != IDLE) && rise_stb && !timeout;
    if (!good) begin
      good_cnt_d = '0;
    end else if (good_cnt_q == LOCK_X) begin
      good_cnt_d = good_cnt_q;
    end else begin
      good_cnt_d = good_cnt_q + GW'(1);
    end
    err_set = locked_q && (timeout || (upd && !good));
    // Set has priority over a simultaneous clear.
    err_d   = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_q         <= 1'b0;
      in_qq        <= 1'b0;
      armed_q      <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      good_cnt_q   <= '0;
    end else begin
      in_q         <= clk_in;
      in_qq        <= in_q;
      armed_q      <= armed_q | ~clk_in;
      period_vld_q <= 1'b0;
      err_q        <= err_d;

      if ((state_q != IDLE) && fall_stb) begin
        high_time_q <= hi_cnt_q;
      end

      case (state_q)
        IDLE: begin
          if (rise_stb) begin
            state_q   <= FIRST;
            per_cnt_q <= CNT_ONE;
            hi_cnt_q  <= CNT_ONE;
          end
        end
        default: begin
          if (timeout) begin
            // Divided clock stopped: drop lock without reporting a period.
            state_q    <= IDLE;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end else if (upd) begin
            state_q      <= TRACK;
            per_cnt_q    <= CNT_ONE;
            hi_cnt_q     <= CNT_ONE;
            period_q     <= per_cnt_q;
            period_vld_q <= 1'b1;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= good && (good_cnt_d == LOCK_X);
          end else begin
            per_cnt_q <= per_cnt_inc_d;
            if (in_q && (hi_cnt_q != CNT_MAX)) begin
              hi_cnt_q <= hi_cnt_inc_d;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;

  logic       clk;
  logic       reset;
  logic       clk_in;
  logic       err_clr;
  logic       rise_stb;
  logic       fall_stb;
  logic [7:0] period;
  logic       period_vld;
  logic [7:0] high_time;
  logic       locked;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int last_vld = 0;
  int vld_gap  = 0;
  int v0       = 0;
  bit lock_seen = 0;
  bit err_seen  = 0;

  clk_div_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .clk_in     (clk_in),
    .err_clr    (err_clr),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .period     (period),
    .period_vld (period_vld),
    .high_time  (high_time),
    .locked     (locked),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present v for the next edge, then sample 1 time unit after that edge.
  task automatic drive(input logic v);
    clk_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (period_vld) begin
      vld_cnt++;
      vld_gap  = cyc - last_vld;
      last_vld = cyc;
    end
    if (locked) lock_seen = 1'b1;
    if (err) err_seen = 1'b1;
  endtask

  task automatic run_pat(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) drive(1'b1);
      for (int i = 0; i < lo; i++) drive(1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0);
    reset = 1'b0;
    drive(1'b0);
    lock_seen = 1'b0;
    err_seen  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rise"}, rise_stb, 0);
    check({tag, "_fall"}, fall_stb, 0);
    check({tag, "_period"}, period, 0);
    check({tag, "_vld"}, period_vld, 0);
    check({tag, "_high"}, high_time, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    reset   = 1'b1;
    clk_in  = 1'b0;
    err_clr = 1'b0;
    drive(1'b0);
    drive(1'b0);
    check_zero("rst");
    reset = 1'b0;
    drive(1'b0);

    // Basic lock on 1100
    vld_cnt = 0; lock_seen = 0; err_seen = 0;
    drive(1'b1);
    check("t1_rise", rise_stb, 1);
    drive(1'b1);
    check("t1_rise_width", rise_stb, 0);
    drive(1'b0);
    check("t1_fall", fall_stb, 1);
    drive(1'b0);
    check("t1_fall_width", fall_stb, 0);
    check("t1_high_time", high_time, 2);
    drive(1'b1);
    check("t1_no_vld_first", vld_cnt, 0);
    drive(1'b1);
    check("t1_vld_2nd_rise", period_vld, 1);
    check("t1_period", period, 4);
    drive(1'b0);
    drive(1'b0);
    run_pat(2, 2, 2);
    check("t1_not_locked_3good", locked, 0);
    run_pat(2, 2, 1);
    check("t1_locked_4good", locked, 1);
    check("t1_vld_cnt", vld_cnt, 4);
    check("t1_vld_gap", vld_gap, 4);
    check("t1_err_seen", err_seen, 0);

    // Wrong ratio 111000
    do_reset();
    run_pat(3, 3, 6);
    check("t2_period", period, 6);
    check("t2_high_time", high_time, 3);
    check("t2_vld_gap", vld_gap, 6);
    check("t2_lock_seen", lock_seen, 0);
    check("t2_err_seen", err_seen, 0);

    // Minimum high/low time: 10
    do_reset();
    run_pat(1, 1, 3);
    check("t7_period", period, 2);
    check("t7_high_time", high_time, 1);
    check("t7_err", err, 0);

    // Loss of lock and relock
    do_reset();
    run_pat(2, 2, 6);
    check("t3_locked", locked, 1);
    run_pat(2, 3, 1);
    run_pat(2, 2, 1);
    check("t3_period5", period, 5);
    check("t3_lock_drop", locked, 0);
    check("t3_err_set", err, 1);
    run_pat(2, 2, 3);
    check("t3_relock_3", locked, 0);
    run_pat(2, 2, 1);
    check("t3_relock_4", locked, 1);
    check("t3_err_sticky", err, 1);
    err_clr = 1'b1;
    drive(1'b1);
    err_clr = 1'b0;
    check("t3_err_clr", err, 0);
    drive(1'b1);
    drive(1'b0);
    drive(1'b0);

    // Clear/set collision
    run_pat(2, 3, 1);
    drive(1'b1);
    err_clr = 1'b1;
    drive(1'b1);
    err_clr = 1'b0;
    check("t5_err_set_wins", err, 1);
    check("t5_locked", locked, 0);
    check("t5_period", period, 5);
    drive(1'b0);
    drive(1'b0);

    // Timeout
    do_reset();
    run_pat(2, 2, 6);
    check("t4_locked", locked, 1);
    v0 = vld_cnt;
    repeat (200) drive(1'b0);
    check("t4_still_locked", locked, 1);
    repeat (100) drive(1'b0);
    check("t4_timeout_locked", locked, 0);
    check("t4_timeout_err", err, 1);
    check("t4_no_vld", vld_cnt, v0);
    run_pat(2, 2, 1);
    check("t4_restart_no_vld", vld_cnt, v0);
    run_pat(2, 2, 1);
    check("t4_restart_vld", vld_cnt, v0 + 1);
    check("t4_restart_period", period, 4);

    // Mid-operation reset with clk_in high at release
    run_pat(2, 2, 3);
    check("t6_locked", locked, 1);
    drive(1'b1);
    reset = 1'b1;
    drive(1'b1);
    check_zero("t6_rst");
    reset = 1'b0;
    drive(1'b1);
    check("t6_no_rise_high", rise_stb, 0);
    drive(1'b0);
    drive(1'b0);
    v0 = vld_cnt;
    drive(1'b1);
    check("t6_first_rise", rise_stb, 1);
    drive(1'b1);
    drive(1'b0);
    drive(1'b0);
    check("t6_no_vld_first", vld_cnt, v0);
    run_pat(2, 2, 1);
    check("t6_vld_2nd", vld_cnt, v0 + 1);
    run_pat(2, 2, 2);
    check("t6_not_locked_3", locked, 0);
    run_pat(2, 2, 1);
    check("t6_relock", locked, 1);
    check("t6_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
